uart_loop_fifo: RTL and testbench
=================================

Name: uart_loop_fifo

Overview:
- Byte buffer between the UART receiver and the UART transmitter in the loopback design.
- Captures each received byte when the receiver's data-valid output rises.
- Stores bytes in a synchronous circular FIFO and issues them one at a time to the transmitter with a start/busy handshake.
- Exposes occupancy and a sticky overflow flag for debug LEDs or a status register.

Parameters:
- DATA_WIDTH, 8, width of each buffered byte; must match the receiver and transmitter data width.
- ADDR_WIDTH, 4, FIFO address width; depth = 2**ADDR_WIDTH (16 entries).
- BUSY_TIMEOUT, 8, cycles to wait in WAIT_BUSY for tx_busy to rise before abandoning the handshake.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- rstn  in  1  asynchronous, active-high reset (rstn=1 resets).
- rx_data  in  DATA_WIDTH  received byte from the UART receiver.
- rx_data_valid  in  1  receiver data-valid. It is level-like and may stay high for many cycles, so only its rising edge marks a new byte.
- tx_busy  in  1  transmitter busy; high while a frame is being sent.
- tx_data  out  DATA_WIDTH  byte presented to the transmitter; held stable from tx_start until the next load.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- fifo_full  out  1  fifo_count == 2**ADDR_WIDTH.
- fifo_empty  out  1  fifo_count == 0.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.
- clr_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rstn=1):
  - tx_data=0, tx_start=0, fifo_count=0, fifo_full=0, fifo_empty=1, overflow=0.
  - Read and write pointers = 0; valid_d = 0; FSM = IDLE.
  - Memory contents are don't-care.
- Reset mid-operation:
  - Any pending byte is discarded.
  - A tx_start pulse in progress is cut.
  - After release, the FSM ignores tx_busy until it is back in IDLE with data present.
- Write side:
  - valid_d registers rx_data_valid each cycle; wr_en = rx_data_valid & ~valid_d.
  - On wr_en with FIFO not full: mem[wr_ptr] <= rx_data, and wr_ptr increments modulo depth.
  - On wr_en with FIFO full: byte dropped; overflow <= 1; pointers and count unchanged.
  - rx_data_valid already high when reset deasserts: valid_d=0, so this counts as a rising edge and the byte is written.
- Overflow flag: when clr_overflow and a new overflow occur in the same cycle, set wins (overflow stays 1).
- Read FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
  - IDLE -> LOAD when ~fifo_empty & ~tx_busy.
  - LOAD, single cycle:
    - tx_data <= mem[rd_ptr]; rd_ptr increments modulo depth.
    - tx_start is registered, high for exactly the one cycle after LOAD, with tx_data already valid.
    - -> WAIT_BUSY.
  - WAIT_BUSY:
    - -> WAIT_DONE when tx_busy=1.
    - Otherwise a timeout counter increments; when it reaches BUSY_TIMEOUT-1, -> IDLE. The byte counts as sent; there is no retry.
  - WAIT_DONE -> IDLE when tx_busy=0.
- Count rules:
  - fifo_count is +1 on an accepted write alone, -1 on a LOAD alone, and unchanged when both happen in the same cycle.
  - Simultaneous write and LOAD when full: LOAD frees a slot in the same cycle, so the write is accepted and no overflow occurs.
  - Simultaneous write and LOAD when count=1: the LOAD reads the old entry; the count stays 1.
- Latency:
  - rx_data_valid rising, sampled at cycle k -> byte in memory and fifo_count updated at k+1.
  - Earliest LOAD at k+1; tx_start high at k+2 (FIFO previously empty, tx_busy=0).
- Pointer width: pointers wrap naturally at ADDR_WIDTH bits; full/empty are derived from fifo_count, never from pointer compare alone.
- Flags fifo_full and fifo_empty are registered together with fifo_count, with no combinational path from inputs.

Test Plan:
- Reset with FIFO holding 3 bytes -> count=0, empty=1, tx_start=0, overflow=0 immediately (async), with no tx_start after release.
- rx_data=0x55, rx_data_valid held high 100 cycles, tx_busy low -> exactly one write, count 0->1->0, a single one-cycle tx_start with tx_data=0x55 at k+2.
- 17 distinct valid edges (0x00..0x10) with tx_busy stuck high -> count=16, full=1, overflow=1, 0x10 dropped. Then tx_busy pulses high 10 cycles per start -> output order 0x00..0x0F, then empty=1.
- FIFO full while a write edge coincides with LOAD -> byte accepted, count stays 16, overflow stays 0.
- tx_busy never rises after tx_start -> FSM returns to IDLE after BUSY_TIMEOUT=8 cycles and the next byte starts.
- overflow=1, then clr_overflow pulsed in the same cycle as a dropped write -> overflow remains 1; clr_overflow alone later -> 0.

Source files
------------

// File: rtl/uart_loop_fifo_if.sv
// Signal bundle between the UART loopback FIFO, the receiver/transmitter pair and status logic.
// The FIFO uses the slave modport; the surrounding logic (or a bench) uses master.
interface uart_loop_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_data_valid;
    logic                  tx_busy;
    logic                  clr_overflow;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_start;
    logic [ADDR_WIDTH:0]   fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  overflow;

    modport master (
        output rx_data, rx_data_valid, tx_busy, clr_overflow,
        input  tx_data, tx_start, fifo_count, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  rx_data, rx_data_valid, tx_busy, clr_overflow,
        output tx_data, tx_start, fifo_count, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/uart_loop_fifo.sv
// Circular byte FIFO between the UART receiver and transmitter in the loopback design.
// Bytes enter on rising edges of rx_data_valid and leave through a start/busy handshake.
module uart_loop_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic            sysclk,
    input  logic            rstn,
    uart_loop_fifo_if.slave bus
);
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int TMO_W      = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int TMO_LAST_I = BUSY_TIMEOUT - 1;
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_LAST_I[TMO_W-1:0];
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = DEPTH[ADDR_WIDTH:0];

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  valid_d;
    logic                  overflow_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_start_q;
    logic [TMO_W-1:0]      tmo_cnt;

    state_t state;
    state_t state_next;

    logic wr_edge;
    logic wr_accept;
    logic wr_drop;
    logic do_load;

    // A LOAD frees a slot in the same cycle, so a write into a full FIFO is still taken.
    assign wr_edge   = bus.rx_data_valid & ~valid_d;
    assign wr_accept = wr_edge & (~full_q | do_load);
    assign wr_drop   = wr_edge & full_q & ~do_load;

    always_ff @(posedge sysclk or posedge rstn) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty_q && !bus.tx_busy) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                do_load    = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_accept, do_load})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sysclk or posedge rstn) begin
        if (rstn) begin
            valid_d    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            valid_d    <= bus.rx_data_valid;
            count_q    <= count_d;
            full_q     <= (count_d == COUNT_FULL);
            empty_q    <= (count_d == '0);
            tx_start_q <= do_load;

            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (do_load) begin
                tx_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_q <= 1'b0;
            end

            if (state == WAIT_BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; stale entries are never read because count gates reads.
    always_ff @(posedge sysclk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.fifo_count = count_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_empty = empty_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Directed bench for uart_loop_fifo: level-valid capture, async reset, overflow,
// full-with-load write, drain order and busy timeout.
module tb_uart_loop_fifo;
    localparam int DW = 8;
    localparam int AW = 4;

    logic sysclk;
    logic rstn;

    int   checks;
    int   failures;
    int   pulses;
    int   gap;
    logic got;

    uart_loop_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_loop_fifo #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .BUSY_TIMEOUT(8)
    ) dut (
        .sysclk(sysclk),
        .rstn  (rstn),
        .bus   (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.rx_data       = b;
        bus.rx_data_valid = 1'b1;
        step(1);
        bus.rx_data_valid = 1'b0;
        step(1);
    endtask

    task automatic wait_start(input string tag, input int budget);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            step(1);
            if (bus.tx_start) got = 1'b1;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rstn              = 1'b1;
        bus.rx_data       = '0;
        bus.rx_data_valid = 1'b0;
        bus.tx_busy       = 1'b0;
        bus.clr_overflow  = 1'b0;

        // Reset values
        step(2);
        check("rst_tx_data",  bus.tx_data, 32'h0);
        check("rst_tx_start", bus.tx_start, 32'h0);
        check("rst_count",    bus.fifo_count, 32'd0);
        check("rst_full",     bus.fifo_full, 32'd0);
        check("rst_empty",    bus.fifo_empty, 32'd1);
        check("rst_overflow", bus.overflow, 32'd0);
        rstn = 1'b0;

        // Level-held valid: one write, tx_start two edges after the capture edge
        bus.rx_data       = 8'h55;
        bus.rx_data_valid = 1'b1;
        step(1);
        check("lvl_count_k",    bus.fifo_count, 32'd1);
        check("lvl_empty_k",    bus.fifo_empty, 32'd0);
        check("lvl_start_k",    bus.tx_start, 32'd0);
        step(1);
        check("lvl_start_k1",   bus.tx_start, 32'd0);
        step(1);
        check("lvl_start_k2",   bus.tx_start, 32'd1);
        check("lvl_data_k2",    bus.tx_data, 32'h55);
        check("lvl_count_k2",   bus.fifo_count, 32'd0);
        check("lvl_empty_k2",   bus.fifo_empty, 32'd1);
        pulses = 0;
        for (int c = 0; c < 97; c++) begin
            step(1);
            if (bus.tx_start) pulses++;
        end
        check("lvl_extra_starts", 32'(pulses), 32'd0);
        check("lvl_count_end",    bus.fifo_count, 32'd0);
        bus.rx_data_valid = 1'b0;
        step(1);

        // Async reset with three bytes queued
        bus.tx_busy = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("pre_rst_count", bus.fifo_count, 32'd3);
        #2 rstn = 1'b1;
        #1;
        check("async_rst_count",    bus.fifo_count, 32'd0);
        check("async_rst_empty",    bus.fifo_empty, 32'd1);
        check("async_rst_tx_start", bus.tx_start, 32'd0);
        check("async_rst_overflow", bus.overflow, 32'd0);
        @(posedge sysclk);
        #1;
        rstn        = 1'b0;
        bus.tx_busy = 1'b0;
        pulses      = 0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (bus.tx_start) pulses++;
        end
        check("post_rst_starts", 32'(pulses), 32'd0);
        check("post_rst_count",  bus.fifo_count, 32'd0);

        // Fill to 16 with the transmitter busy, then drop the 17th byte
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("fill_count",    bus.fifo_count, 32'd16);
        check("fill_full",     bus.fifo_full, 32'd1);
        check("fill_overflow", bus.overflow, 32'd0);
        push(8'h10);
        check("drop_count",    bus.fifo_count, 32'd16);
        check("drop_full",     bus.fifo_full, 32'd1);
        check("drop_overflow", bus.overflow, 32'd1);

        // Clear colliding with another drop: set wins
        bus.rx_data       = 8'h11;
        bus.rx_data_valid = 1'b1;
        bus.clr_overflow  = 1'b1;
        step(1);
        check("clr_vs_drop_overflow", bus.overflow, 32'd1);
        bus.rx_data_valid = 1'b0;
        bus.clr_overflow  = 1'b0;
        step(1);
        bus.clr_overflow  = 1'b1;
        step(1);
        bus.clr_overflow  = 1'b0;
        check("clr_alone_overflow", bus.overflow, 32'd0);
        check("clr_alone_count",    bus.fifo_count, 32'd16);

        // Drain with a 10-cycle busy pulse per start; order must be 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            bus.tx_busy = 1'b0;
            wait_start($sformatf("drain_start_%0d", i), 20);
            check($sformatf("drain_data_%0d", i), bus.tx_data, 32'(i));
            bus.tx_busy = 1'b1;
            step(10);
        end
        bus.tx_busy = 1'b0;
        step(3);
        check("drain_empty", bus.fifo_empty, 32'd1);
        check("drain_count", bus.fifo_count, 32'd0);

        // Full FIFO: write edge lands in the LOAD cycle and is accepted
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
        check("refill_count", bus.fifo_count, 32'd16);
        bus.tx_busy = 1'b0;
        step(1);
        bus.rx_data       = 8'hB0;
        bus.rx_data_valid = 1'b1;
        bus.tx_busy       = 1'b1;
        step(1);
        bus.rx_data_valid = 1'b0;
        check("coll_tx_start", bus.tx_start, 32'd1);
        check("coll_tx_data",  bus.tx_data, 32'hA0);
        check("coll_count",    bus.fifo_count, 32'd16);
        check("coll_full",     bus.fifo_full, 32'd1);
        check("coll_overflow", bus.overflow, 32'd0);
        step(1);
        check("coll_pulse_width", bus.tx_start, 32'd0);

        // tx_busy never rises: next start comes 10 edges later (8 in WAIT_BUSY + IDLE + LOAD)
        bus.tx_busy = 1'b0;
        wait_start("tmo_first_start", 20);
        check("tmo_first_data", bus.tx_data, 32'hA1);
        gap = 0;
        for (int c = 1; c <= 30 && gap == 0; c++) begin
            step(1);
            if (bus.tx_start) gap = c;
        end
        check("tmo_gap",       32'(gap), 32'd10);
        check("tmo_next_data", bus.tx_data, 32'hA2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
